// File: rtl/peaks_frame_fifo.sv
// Frame FIFO behind the peak finder: each rising edge of valid_in captures
// {counter, freqs, amplitudes} as one frame; the host reads the head byte-wise and pops it.
module peaks_frame_fifo #(
  parameter int unsigned PEAKS      = 6,
  parameter int unsigned FREQ_WIDTH = 8,
  parameter int unsigned AMPL_WIDTH = 24,
  parameter int unsigned TIME_WIDTH = 32,
  parameter int unsigned DEPTH      = 8
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         valid_in,
  input  logic [TIME_WIDTH-1:0]        counter_in,
  input  logic [PEAKS*FREQ_WIDTH-1:0]  freqs_in,
  input  logic [PEAKS*AMPL_WIDTH-1:0]  amplitudes_in,
  input  logic                         chipselect,
  input  logic                         write,
  input  logic [7:0]                   address,
  input  logic [7:0]                   writedata,
  output logic [7:0]                   readdata,
  output logic                         fifo_empty,
  output logic                         fifo_full
);

  localparam int unsigned TB          = TIME_WIDTH / 8;
  localparam int unsigned AB          = AMPL_WIDTH / 8;
  localparam int unsigned FRAME_BYTES = TB + PEAKS + PEAKS * AB;
  localparam int unsigned PW          = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW          = PW + 1;

  logic                        valid_q;
  logic [PW-1:0]               wptr_q, wptr_d;
  logic [PW-1:0]               rptr_q, rptr_d;
  logic [LW-1:0]               level_q, level_d;
  logic                        empty_q, empty_d;
  logic                        full_q, full_d;
  logic                        ovf_q, ovf_d;
  logic [7:0]                  drop_q, drop_d;
  logic [7:0]                  rdata_q, rdata_d;

  logic                        ctrl_wr, push, pop, clear, store;
  logic                        unused_wd;

  logic [TIME_WIDTH-1:0]       mem_cnt  [DEPTH];
  logic [PEAKS*FREQ_WIDTH-1:0] mem_freq [DEPTH];
  logic [PEAKS*AMPL_WIDTH-1:0] mem_ampl [DEPTH];

  logic [TIME_WIDTH-1:0]       head_cnt;
  logic [PEAKS*FREQ_WIDTH-1:0] head_freq;
  logic [PEAKS*AMPL_WIDTH-1:0] head_ampl;
  logic [FRAME_BYTES*8-1:0]    frame_flat;

  always_comb begin
    ctrl_wr   = chipselect & write & (address == 8'hF8);
    push      = valid_in & ~valid_q;
    pop       = ctrl_wr & writedata[0] & ~empty_q;
    clear     = ctrl_wr & writedata[1];
    // A pop frees the slot on the same edge, so a push while full is still stored.
    store     = push & (~full_q | pop);
    unused_wd = ^writedata[7:2];
  end

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    level_d = level_q;
    ovf_d   = ovf_q;
    drop_d  = drop_q;
    if (store) wptr_d = wptr_q + PW'(1);
    if (pop)   rptr_d = rptr_q + PW'(1);
    if (store && !pop)      level_d = level_q + LW'(1);
    else if (pop && !store) level_d = level_q - LW'(1);
    if (push && !store) begin
      ovf_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
    end
    if (clear) begin
      ovf_d  = 1'b0;
      drop_d = '0;
    end
    empty_d = (level_d == '0);
    full_d  = (level_d == LW'(DEPTH));
  end

  // Head frame laid out as a flat byte string, every field MSB first.
  always_comb begin
    head_cnt   = mem_cnt[rptr_q];
    head_freq  = mem_freq[rptr_q];
    head_ampl  = mem_ampl[rptr_q];
    frame_flat = '0;
    for (int unsigned i = 0; i < TB; i++)
      frame_flat[i*8 +: 8] = head_cnt[(TB-1-i)*8 +: 8];
    for (int unsigned p = 0; p < PEAKS; p++)
      frame_flat[(TB+p)*8 +: 8] = 8'(head_freq[p*FREQ_WIDTH +: FREQ_WIDTH]);
    for (int unsigned p = 0; p < PEAKS; p++)
      for (int unsigned b = 0; b < AB; b++)
        frame_flat[(TB+PEAKS+p*AB+b)*8 +: 8] = head_ampl[p*AMPL_WIDTH + (AB-1-b)*8 +: 8];
  end

  always_comb begin
    rdata_d = '0;
    for (int unsigned i = 0; i < FRAME_BYTES; i++)
      if (!empty_q && address == 8'(i)) rdata_d = frame_flat[i*8 +: 8];
    case (address)
      8'hF0:   rdata_d = 8'(level_q);
      8'hF1:   rdata_d = {5'b0, ovf_q, full_q, empty_q};
      8'hF2:   rdata_d = drop_q;
      8'hFF:   rdata_d = 8'h5A;
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid_q <= 1'b0;
      wptr_q  <= '0;
      rptr_q  <= '0;
      level_q <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
      drop_q  <= '0;
      rdata_q <= '0;
    end else begin
      valid_q <= valid_in;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      level_q <= level_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
      drop_q  <= drop_d;
      rdata_q <= rdata_d;
    end
  end

  always_ff @(posedge clk) begin
    if (store) begin
      mem_cnt[wptr_q]  <= counter_in;
      mem_freq[wptr_q] <= freqs_in;
      mem_ampl[wptr_q] <= amplitudes_in;
    end
  end

  always_comb begin
    readdata   = rdata_q;
    fifo_empty = empty_q;
    fifo_full  = full_q;
  end

endmodule

// File: tb/tb_peaks_frame_fifo.sv
// Scoreboarded bench for peaks_frame_fifo: reads queue their expected byte,
// a monitor compares readdata one cycle after each read address is presented.
module tb_peaks_frame_fifo;

  logic         clk = 1'b0;
  logic         reset;
  logic         valid_in;
  logic [31:0]  counter_in;
  logic [47:0]  freqs_in;
  logic [143:0] amplitudes_in;
  logic         chipselect;
  logic         write;
  logic [7:0]   address;
  logic [7:0]   writedata;
  logic [7:0]   readdata;
  logic         fifo_empty;
  logic         fifo_full;

  int           n_checks = 0;
  int           n_errors = 0;
  logic         rd_req   = 1'b0;
  logic         rd_pend  = 1'b0;
  logic [7:0]   exp_q [$];
  string        name_q [$];

  peaks_frame_fifo #(
    .PEAKS(6), .FREQ_WIDTH(8), .AMPL_WIDTH(24), .TIME_WIDTH(32), .DEPTH(8)
  ) dut (
    .clk(clk), .reset(reset), .valid_in(valid_in), .counter_in(counter_in),
    .freqs_in(freqs_in), .amplitudes_in(amplitudes_in), .chipselect(chipselect),
    .write(write), .address(address), .writedata(writedata), .readdata(readdata),
    .fifo_empty(fifo_empty), .fifo_full(fifo_full)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  always @(posedge clk) rd_pend <= rd_req;

  always @(negedge clk) begin
    if (rd_pend) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'(exp_q.size()), 32'd1);
      else check(name_q.pop_front(), {24'h0, readdata}, {24'h0, exp_q.pop_front()});
    end
  end

  task automatic step();
    @(negedge clk);
    chipselect = 1'b0;
    write      = 1'b0;
    writedata  = 8'h00;
    rd_req     = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [7:0] exp, input string name);
    step();
    address = a;
    rd_req  = 1'b1;
    exp_q.push_back(exp);
    name_q.push_back(name);
  endtask

  task automatic wr(input logic [7:0] a, input logic [7:0] d);
    step();
    chipselect = 1'b1;
    write      = 1'b1;
    address    = a;
    writedata  = d;
  endtask

  task automatic push_cnt(input logic [31:0] cnt);
    step();
    counter_in = cnt;
    valid_in   = 1'b1;
    step();
    valid_in   = 1'b0;
  endtask

  // Push on the same edge as a control write to 0xF8 carrying wd.
  task automatic push_ctrl(input logic [31:0] cnt, input logic [7:0] wd);
    step();
    counter_in = cnt;
    valid_in   = 1'b1;
    chipselect = 1'b1;
    write      = 1'b1;
    address    = 8'hF8;
    writedata  = wd;
    step();
    valid_in   = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", n_checks);
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] f1_exp [16];
    f1_exp = '{8'h12, 8'h34, 8'h56, 8'h78, 8'h01, 8'h02, 8'h03, 8'h04,
               8'h05, 8'h06, 8'hAB, 8'hCD, 8'hEF, 8'h11, 8'h22, 8'h33};
    reset = 1'b0; valid_in = 1'b0; counter_in = '0; freqs_in = '0; amplitudes_in = '0;
    chipselect = 1'b0; write = 1'b0; address = 8'h00; writedata = 8'h00;
    repeat (2) @(negedge clk);
    check("rst_readdata", {24'h0, readdata}, 32'h0);
    check("rst_empty", {31'h0, fifo_empty}, 32'h1);
    check("rst_full", {31'h0, fifo_full}, 32'h0);
    reset = 1'b1;

    rd(8'hF1, 8'h01, "status_reset");
    rd(8'hFF, 8'h5A, "block_id");
    rd(8'hF0, 8'h00, "level_reset");
    rd(8'hF2, 8'h00, "drop_reset");

    // Single frame, then byte-map readout
    freqs_in      = {8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
    amplitudes_in = {24'h0, 24'h0, 24'h0, 24'h0, 24'h112233, 24'hABCDEF};
    push_cnt(32'h12345678);
    for (int i = 0; i < 16; i++) rd(8'(i), f1_exp[i], $sformatf("frame_byte%0d", i));
    rd(8'd27, 8'h00, "frame_byte27");
    rd(8'd28, 8'h00, "unmapped_28");
    rd(8'h80, 8'h00, "unmapped_80");
    rd(8'hF0, 8'h01, "level_one");
    rd(8'hF1, 8'h00, "status_one");
    wr(8'hF8, 8'h01);
    rd(8'hF0, 8'h00, "level_after_pop");
    rd(8'h00, 8'h00, "empty_frame_byte");
    rd(8'hF1, 8'h01, "status_after_pop");

    // valid_in held high for 10 cycles pushes once
    step();
    counter_in = 32'hCAFE0001;
    valid_in   = 1'b1;
    repeat (10) step();
    valid_in   = 1'b0;
    rd(8'hF0, 8'h01, "held_level");
    rd(8'h03, 8'h01, "held_cnt");
    wr(8'hF8, 8'h01);
    rd(8'hF0, 8'h00, "held_level_pop");

    // Overfill with counters 0..9, then drain
    for (int i = 0; i < 10; i++) push_cnt(32'(i));
    check("full_flag", {31'h0, fifo_full}, 32'h1);
    rd(8'hF0, 8'h08, "level_full");
    rd(8'hF1, 8'h06, "status_overflow");
    rd(8'hF2, 8'h02, "drop_count");
    for (int i = 0; i < 8; i++) begin
      rd(8'h03, 8'(i), $sformatf("drain_cnt%0d", i));
      wr(8'hF8, 8'h01);
    end
    step();
    check("drained_empty", {31'h0, fifo_empty}, 32'h1);
    rd(8'hF0, 8'h00, "level_drained");
    rd(8'hF1, 8'h05, "status_drained_ovf");

    // Clear, then pop when empty
    wr(8'hF8, 8'h02);
    rd(8'hF1, 8'h01, "status_cleared");
    rd(8'hF2, 8'h00, "drop_cleared");
    wr(8'hF8, 8'h01);
    rd(8'hF0, 8'h00, "level_empty_pop");
    rd(8'hF1, 8'h01, "status_empty_pop");
    push_cnt(32'h00000077);
    rd(8'h03, 8'h77, "no_ptr_wrap");
    wr(8'hF8, 8'h01);

    // Full: push+pop same edge, then push+clear while full
    for (int i = 0; i < 8; i++) push_cnt(32'h10 + 32'(i));
    rd(8'hF0, 8'h08, "level_refill");
    push_ctrl(32'h18, 8'h01);
    rd(8'hF0, 8'h08, "level_push_pop");
    rd(8'hF2, 8'h00, "drop_push_pop");
    rd(8'h03, 8'h11, "head_advanced");
    rd(8'hF1, 8'h02, "status_full_no_ovf");
    push_ctrl(32'h99, 8'h02);
    rd(8'hF1, 8'h02, "clear_beats_drop");
    rd(8'hF2, 8'h00, "drop_clear_wins");
    for (int i = 0; i < 7; i++) begin
      rd(8'h03, 8'h11 + 8'(i), $sformatf("drain2_cnt%0d", i));
      wr(8'hF8, 8'h01);
    end
    rd(8'h03, 8'h18, "tail_is_pushed");
    wr(8'hF8, 8'h01);
    rd(8'hF1, 8'h01, "status_drained2");

    // Reset mid-operation after an overflow
    for (int i = 0; i < 9; i++) push_cnt(32'h20 + 32'(i));
    rd(8'hF0, 8'h08, "level_before_reset");
    rd(8'hF2, 8'h01, "drop_before_reset");
    step();
    @(negedge clk);
    reset = 1'b0;
    #1;
    check("async_rst_empty", {31'h0, fifo_empty}, 32'h1);
    check("async_rst_full", {31'h0, fifo_full}, 32'h0);
    check("async_rst_readdata", {24'h0, readdata}, 32'h0);
    repeat (2) @(negedge clk);
    reset = 1'b1;
    rd(8'hF0, 8'h00, "level_after_reset");
    rd(8'hF1, 8'h01, "status_after_reset");
    rd(8'hF2, 8'h00, "drop_after_reset");

    repeat (3) step();
    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
